// File: rtl/cpu_pkg.sv
// Shared widths and control encodings for the CPU datapath.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int RF_AW   = 4;
    localparam int DMEM_AW = 8;

    typedef enum logic [1:0] {
        ALU_PASSP = 2'b00,
        ALU_ADD   = 2'b01,
        ALU_SUB   = 2'b10,
        ALU_PASSQ = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_IMM  = 2'b10,
        WB_ZERO = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two gated combinational read ports, one write port,
// one debug read port, asynchronous active-low clear.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RF_AW-1:0]  w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    input  logic [RF_AW-1:0]  rp_addr,
    input  logic              rp_rd,
    output logic [DATA_W-1:0] rp_data,
    input  logic [RF_AW-1:0]  rq_addr,
    input  logic              rq_rd,
    output logic [DATA_W-1:0] rq_data,
    input  logic [RF_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [DEPTH];

    // Register array: cleared asynchronously, written on the rising edge.
    // Reads below see the pre-edge value, so there is no write bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[w_addr] <= w_data;
        end
    end

    // Gated read ports: a disabled port reads as zero.
    always_comb begin
        rp_data  = rp_rd ? regs[rp_addr] : '0;
        rq_data  = rq_rd ? regs[rq_addr] : '0;
        dbg_data = regs[dbg_addr];
    end

endmodule

// File: rtl/datapath.sv
// Execution datapath: register file, ALU, write-back mux and data memory.
// All sequencing is owned by the controller; this block only reacts.
module datapath
    import cpu_pkg::*;
#(
    parameter int    DATA_W     = 8,
    parameter int    RF_DEPTH   = 16,
    parameter int    DMEM_DEPTH = 256,
    parameter string DMEM_INIT  = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DMEM_AW-1:0] D_addr,
    input  logic               D_rd,
    input  logic               D_wr,
    input  logic [DATA_W-1:0]  RF_W_data,
    input  logic               RF_s1,
    input  logic               RF_s0,
    input  logic [RF_AW-1:0]   RF_W_addr,
    input  logic               RF_W_wr,
    input  logic [RF_AW-1:0]   RF_Rp_addr,
    input  logic               RF_Rp_rd,
    input  logic [RF_AW-1:0]   RF_Rq_addr,
    input  logic               RF_Rq_rd,
    input  logic               alu_s1,
    input  logic               alu_s0,
    output logic               RF_Rp_zero,
    input  logic [RF_AW-1:0]   dbg_rf_addr,
    output logic [DATA_W-1:0]  dbg_rf_data,
    input  logic [DMEM_AW-1:0] dbg_mem_addr,
    output logic [DATA_W-1:0]  dbg_mem_data
);

    logic [DATA_W-1:0] rp_data;
    logic [DATA_W-1:0] rq_data;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    alu_op_e           alu_op;
    wb_sel_e           wb_sel;

    assign alu_op = alu_op_e'({alu_s1, alu_s0});
    assign wb_sel = wb_sel_e'({RF_s1, RF_s0});

    regfile_2r1w #(
        .DEPTH (RF_DEPTH)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst),
        .w_addr   (RF_W_addr),
        .w_data   (wb_data),
        .w_en     (RF_W_wr),
        .rp_addr  (RF_Rp_addr),
        .rp_rd    (RF_Rp_rd),
        .rp_data  (rp_data),
        .rq_addr  (RF_Rq_addr),
        .rq_rd    (RF_Rq_rd),
        .rq_data  (rq_data),
        .dbg_addr (dbg_rf_addr),
        .dbg_data (dbg_rf_data)
    );

    // ALU: modulo-2^8 arithmetic, carry and borrow dropped.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_PASSP: alu_out = rp_data;
            ALU_ADD:   alu_out = rp_data + rq_data;
            ALU_SUB:   alu_out = rp_data - rq_data;
            ALU_PASSQ: alu_out = rq_data;
            default:   alu_out = '0;
        endcase
    end

    // Write-back select and asynchronous memory read, so a load fits in one state.
    always_comb begin
        dmem_rdata = D_rd ? dmem[D_addr] : '0;
        wb_data    = '0;
        case (wb_sel)
            WB_ALU:  wb_data = alu_out;
            WB_MEM:  wb_data = dmem_rdata;
            WB_IMM:  wb_data = RF_W_data;
            WB_ZERO: wb_data = '0;
            default: wb_data = '0;
        endcase
    end

    // Data memory store: never cleared, but a store is dropped while reset is held.
    always_ff @(posedge clk) begin
        if (D_wr && rst) begin
            dmem[D_addr] <= rp_data;
        end
    end

    // Zero flag lets the controller resolve jump-if-zero in the same cycle.
    always_comb begin
        RF_Rp_zero   = RF_Rp_rd && (rp_data == '0);
        dbg_mem_data = dmem[dbg_mem_addr];
    end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: reset, directed corner sequences, a vector table and
// randomized cycles checked against a behavioural model.
module tb_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] D_addr;
    logic       D_rd, D_wr;
    logic [7:0] RF_W_data;
    logic       RF_s1, RF_s0;
    logic [3:0] RF_W_addr;
    logic       RF_W_wr;
    logic [3:0] RF_Rp_addr;
    logic       RF_Rp_rd;
    logic [3:0] RF_Rq_addr;
    logic       RF_Rq_rd;
    logic       alu_s1, alu_s0;
    logic       RF_Rp_zero;
    logic [3:0] dbg_rf_addr;
    logic [7:0] dbg_rf_data;
    logic [7:0] dbg_mem_addr;
    logic [7:0] dbg_mem_data;

    int tests  = 0;
    int failed = 0;

    logic [7:0] m_rf  [16];
    logic [7:0] m_mem [256];

    always #5 clk = ~clk;

    datapath dut (
        .clk          (clk),
        .rst          (rst),
        .D_addr       (D_addr),
        .D_rd         (D_rd),
        .D_wr         (D_wr),
        .RF_W_data    (RF_W_data),
        .RF_s1        (RF_s1),
        .RF_s0        (RF_s0),
        .RF_W_addr    (RF_W_addr),
        .RF_W_wr      (RF_W_wr),
        .RF_Rp_addr   (RF_Rp_addr),
        .RF_Rp_rd     (RF_Rp_rd),
        .RF_Rq_addr   (RF_Rq_addr),
        .RF_Rq_rd     (RF_Rq_rd),
        .alu_s1       (alu_s1),
        .alu_s0       (alu_s0),
        .RF_Rp_zero   (RF_Rp_zero),
        .dbg_rf_addr  (dbg_rf_addr),
        .dbg_rf_data  (dbg_rf_data),
        .dbg_mem_addr (dbg_mem_addr),
        .dbg_mem_data (dbg_mem_data)
    );

    typedef struct {
        logic [3:0] p;
        logic       prd;
        logic [3:0] q;
        logic       qrd;
        logic [1:0] alu;
        logic [1:0] sel;
        logic [7:0] imm;
        logic [3:0] dst;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        D_addr = '0; D_rd = 0; D_wr = 0;
        RF_W_data = '0; RF_s1 = 0; RF_s0 = 0;
        RF_W_addr = '0; RF_W_wr = 0;
        RF_Rp_addr = '0; RF_Rp_rd = 0;
        RF_Rq_addr = '0; RF_Rq_rd = 0;
        alu_s1 = 0; alu_s0 = 0;
    endtask

    // One clock edge; the model commits what the spec says this edge should commit.
    task automatic cyc();
        logic [7:0] rp, rq, alu, mrd, wb;
        rp  = RF_Rp_rd ? m_rf[RF_Rp_addr] : 8'h00;
        rq  = RF_Rq_rd ? m_rf[RF_Rq_addr] : 8'h00;
        case ({alu_s1, alu_s0})
            2'd0:    alu = rp;
            2'd1:    alu = 8'((int'(rp) + int'(rq)) % 256);
            2'd2:    alu = 8'((int'(rp) - int'(rq) + 256) % 256);
            default: alu = rq;
        endcase
        mrd = D_rd ? m_mem[D_addr] : 8'h00;
        case ({RF_s1, RF_s0})
            2'd0:    wb = alu;
            2'd1:    wb = mrd;
            2'd2:    wb = RF_W_data;
            default: wb = 8'h00;
        endcase
        @(posedge clk);
        if (rst) begin
            if (RF_W_wr) m_rf[RF_W_addr] = wb;
            if (D_wr)    m_mem[D_addr] = rp;
        end
        #1;
    endtask

    task automatic wr_imm(input logic [3:0] a, input logic [7:0] v);
        idle();
        RF_W_addr = a; RF_W_data = v; RF_s1 = 1; RF_s0 = 0; RF_W_wr = 1;
        cyc();
        idle();
    endtask

    task automatic chk_reg(input string name, input logic [3:0] a, input logic [7:0] v);
        dbg_rf_addr = a;
        #1;
        check(name, dbg_rf_data, v);
    endtask

    task automatic chk_mem(input string name, input logic [7:0] a, input logic [7:0] v);
        dbg_mem_addr = a;
        #1;
        check(name, dbg_mem_data, v);
    endtask

    initial begin
        vecs[0] = '{p:10, prd:1, q:11, qrd:1, alu:2'b01, sel:2'b00, imm:8'h00, dst:15, exp:8'hFF};
        vecs[1] = '{p:12, prd:1, q:13, qrd:1, alu:2'b01, sel:2'b00, imm:8'h00, dst:15, exp:8'h00};
        vecs[2] = '{p:13, prd:1, q:12, qrd:1, alu:2'b10, sel:2'b00, imm:8'h00, dst:15, exp:8'h02};
        vecs[3] = '{p:10, prd:1, q:11, qrd:1, alu:2'b10, sel:2'b00, imm:8'h00, dst:15, exp:8'h01};
        vecs[4] = '{p:12, prd:1, q:11, qrd:1, alu:2'b00, sel:2'b00, imm:8'h00, dst:15, exp:8'hFF};
        vecs[5] = '{p:12, prd:1, q:11, qrd:1, alu:2'b11, sel:2'b00, imm:8'h00, dst:15, exp:8'h7F};
        vecs[6] = '{p:12, prd:1, q:13, qrd:0, alu:2'b01, sel:2'b00, imm:8'h00, dst:15, exp:8'hFF};
        vecs[7] = '{p:12, prd:0, q:13, qrd:1, alu:2'b00, sel:2'b00, imm:8'h00, dst:15, exp:8'h00};
        vecs[8] = '{p:12, prd:1, q:13, qrd:1, alu:2'b01, sel:2'b10, imm:8'h5A, dst:15, exp:8'h5A};
        vecs[9] = '{p:12, prd:1, q:13, qrd:1, alu:2'b01, sel:2'b11, imm:8'h5A, dst:15, exp:8'h00};

        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

        // Reset state
        rst = 0;
        idle();
        dbg_rf_addr = '0; dbg_mem_addr = '0;
        #2;
        for (int i = 0; i < 16; i++) chk_reg("reset_rf", 4'(i), 8'h00);
        check("reset_zero_rd0", RF_Rp_zero, 1'b0);
        RF_Rp_rd = 1;
        #1;
        check("reset_zero_rd1", RF_Rp_zero, 1'b1);
        idle();
        @(posedge clk); #2;
        rst = 1;

        // Clear data memory to known zeros (Rp disabled reads as 0)
        for (int i = 0; i < 256; i++) begin
            idle(); D_addr = 8'(i); D_wr = 1;
            cyc();
        end
        idle();
        chk_mem("mem_clear", 8'hC3, 8'h00);

        // Immediate load
        wr_imm(3, 8'h2A);
        RF_Rp_addr = 3; RF_Rp_rd = 1;
        chk_reg("imm_r3", 3, 8'h2A);
        check("imm_zero", RF_Rp_zero, 1'b0);

        // Add with wrap
        wr_imm(1, 8'hF0);
        wr_imm(2, 8'h20);
        RF_Rp_addr = 1; RF_Rp_rd = 1; RF_Rq_addr = 2; RF_Rq_rd = 1;
        alu_s0 = 1; RF_W_addr = 4; RF_W_wr = 1;
        cyc(); idle();
        chk_reg("add_wrap_r4", 4, 8'h10);

        // Store then single-cycle load
        wr_imm(5, 8'h77);
        RF_Rp_addr = 5; RF_Rp_rd = 1; D_addr = 8'h80; D_wr = 1;
        cyc(); idle();
        chk_mem("store_80", 8'h80, 8'h77);
        D_addr = 8'h80; D_rd = 1; RF_s0 = 1; RF_W_addr = 6; RF_W_wr = 1;
        cyc(); idle();
        chk_reg("load_r6", 6, 8'h77);

        // Read during write returns old value
        wr_imm(7, 8'h01);
        RF_Rp_addr = 7; RF_Rp_rd = 1;
        RF_W_addr = 7; RF_s1 = 1; RF_W_data = 8'h00; RF_W_wr = 1;
        #1;
        check("rdw_zero_old", RF_Rp_zero, 1'b0);
        cyc();
        RF_W_wr = 0;
        #1;
        check("rdw_zero_new", RF_Rp_zero, 1'b1);
        idle();

        // Zero flag gating and self-subtract
        wr_imm(0, 8'h00);
        RF_Rp_addr = 0; RF_Rp_rd = 0;
        #1;
        check("zero_gated", RF_Rp_zero, 1'b0);
        RF_Rp_rd = 1;
        #1;
        check("zero_r0", RF_Rp_zero, 1'b1);
        wr_imm(8, 8'h55);
        wr_imm(9, 8'hFF);
        RF_Rp_addr = 8; RF_Rp_rd = 1; RF_Rq_addr = 8; RF_Rq_rd = 1;
        alu_s1 = 1; RF_W_addr = 9; RF_W_wr = 1;
        cyc(); idle();
        chk_reg("sub_self_r9", 9, 8'h00);

        // Same-address load and store; also RF and dmem written on one edge
        RF_Rp_addr = 3; RF_Rp_rd = 1; D_addr = 8'h80; D_rd = 1; D_wr = 1;
        RF_s0 = 1; RF_W_addr = 14; RF_W_wr = 1;
        cyc(); idle();
        chk_reg("rw_mem_old_r14", 14, 8'h77);
        chk_mem("rw_mem_new_80", 8'h80, 8'h2A);

        // Table-driven ALU / write-back vectors
        wr_imm(10, 8'h80);
        wr_imm(11, 8'h7F);
        wr_imm(12, 8'hFF);
        wr_imm(13, 8'h01);
        for (int i = 0; i < 10; i++) begin
            idle();
            RF_Rp_addr = vecs[i].p; RF_Rp_rd = vecs[i].prd;
            RF_Rq_addr = vecs[i].q; RF_Rq_rd = vecs[i].qrd;
            {alu_s1, alu_s0} = vecs[i].alu;
            {RF_s1, RF_s0} = vecs[i].sel;
            RF_W_data = vecs[i].imm;
            RF_W_addr = vecs[i].dst; RF_W_wr = 1;
            cyc(); idle();
            chk_reg($sformatf("vec%0d", i), vecs[i].dst, vecs[i].exp);
        end

        // Randomized cycles against the model
        for (int n = 0; n < 400; n++) begin
            D_addr = 8'($urandom_range(0, 255));
            if (n % 3 == 0) D_addr = 8'($urandom_range(0, 7));
            D_rd = 1'($urandom); D_wr = 1'($urandom);
            RF_W_data = 8'($urandom);
            {RF_s1, RF_s0} = 2'($urandom);
            RF_W_addr = 4'($urandom); RF_W_wr = 1'($urandom);
            RF_Rp_addr = 4'($urandom); RF_Rp_rd = ($urandom_range(0, 3) != 0);
            RF_Rq_addr = 4'($urandom); RF_Rq_rd = ($urandom_range(0, 3) != 0);
            {alu_s1, alu_s0} = 2'($urandom);
            dbg_rf_addr = 4'($urandom);
            dbg_mem_addr = 8'($urandom_range(0, 7));
            #1;
            check("rnd_zero", RF_Rp_zero,
                  (RF_Rp_rd && m_rf[RF_Rp_addr] == 8'h00) ? 1'b1 : 1'b0);
            check("rnd_rf", dbg_rf_data, m_rf[dbg_rf_addr]);
            check("rnd_mem", dbg_mem_data, m_mem[dbg_mem_addr]);
            cyc();
        end
        idle();
        for (int i = 0; i < 16; i++) chk_reg("rnd_final_rf", 4'(i), m_rf[i]);

        // Async reset mid-write: nothing commits, registers clear at once
        wr_imm(2, 8'h33);
        m_mem[8'h10] = dbg_mem_data;
        dbg_mem_addr = 8'h10;
        #1;
        m_mem[8'h10] = dbg_mem_data;
        RF_Rp_addr = 2; RF_Rp_rd = 1; D_addr = 8'h10; D_wr = 1;
        RF_W_addr = 2; RF_s1 = 1; RF_W_data = 8'hAA; RF_W_wr = 1;
        #2;
        rst = 0;
        #1;
        chk_reg("rstmid_r2", 2, 8'h00);
        chk_reg("rstmid_r3", 3, 8'h00);
        cyc();
        idle();
        rst = 1;
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        cyc();
        chk_reg("rstmid_r2_after", 2, 8'h00);
        chk_mem("rstmid_mem", 8'h10, m_mem[8'h10]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution half of the simple CPU; sits directly downstream of the control unit and consumes every RF_*, D_*, and alu_* control it drives.
- Holds the 16x8 register file, the ALU, the write-back select mux, and an internal 256x8 data memory.
- Returns RF_Rp_zero to the controller so it can resolve jump-if-zero in the same cycle.

Parameters:
DATA_W, 8, datapath word width
RF_DEPTH, 16, register count (address width 4)
DMEM_DEPTH, 256, data memory words (address width 8)
DMEM_INIT, "", optional hex init file for data memory; empty means no init

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
D_addr  in  8  data memory address
D_rd  in  1  data memory read enable
D_wr  in  1  data memory write enable (write data = Rp read data)
RF_W_data  in  8  immediate write-back value from instruction
RF_s1  in  1  write-back select bit 1
RF_s0  in  1  write-back select bit 0
RF_W_addr  in  4  register write address
RF_W_wr  in  1  register write enable
RF_Rp_addr  in  4  port-P read address
RF_Rp_rd  in  1  port-P read enable
RF_Rq_addr  in  4  port-Q read address
RF_Rq_rd  in  1  port-Q read enable
alu_s1  in  1  ALU op bit 1
alu_s0  in  1  ALU op bit 0
RF_Rp_zero  out  1  high when RF_Rp_rd=1 and Rp data == 0
dbg_rf_addr  in  4  verification read address into register file
dbg_rf_data  out  8  combinational content of register dbg_rf_addr
dbg_mem_addr  in  8  verification read address into data memory
dbg_mem_data  out  8  combinational content of dmem[dbg_mem_addr]

Behaviour:
- Reset (rst=0, async): all 16 registers clear to 0; data memory is not cleared.
  - Outputs after reset: RF_Rp_zero=0 unless Rp_rd is already asserted (then 1); dbg_rf_data=0.
- Register reads:
  - Rp_data = RF_Rp_rd ? rf[Rp_addr] : 0; Rq_data likewise.
  - Reads are combinational, zero latency.
- Register write: on posedge when RF_W_wr=1, rf[W_addr] <= wb_data.
  - A read of the same address in the write cycle returns the OLD value; no bypass.
- Write-back mux {RF_s1,RF_s0}: 00 = ALU result, 01 = dmem read data, 10 = RF_W_data, 11 = 8'h00.
- ALU {alu_s1,alu_s0}, purely combinational:
  - 00 = Rp_data (pass)
  - 01 = Rp_data + Rq_data
  - 10 = Rp_data - Rq_data
  - 11 = Rq_data (pass)
  - Arithmetic is modulo 2^8; carry/borrow discarded.
  - The controller currently drives only alu_s0; alu_s1 is tied low at integration, so ops 10/11 are reserved for the next ISA revision.
- Data memory:
  - Asynchronous read: dmem_rdata = D_rd ? dmem[D_addr] : 0, so a load completes in one state (D_rd, RF_W_wr, s=01 in the same cycle).
  - Synchronous write: on posedge with D_wr=1, dmem[D_addr] <= Rp_data.
  - D_rd and D_wr both high on the same address: read returns the old value and the write lands at the edge.
- Simultaneous RF_W_wr and D_wr: both commit on the same edge, independently.
- Reset mid-operation: the register write in that cycle is suppressed; a pending dmem write is also suppressed (gated by rst).
- RF_Rp_zero: combinational, same cycle as Rp_addr/Rp_rd; 0 when Rp_rd=0.
- Out-of-range addresses cannot occur (widths exact); no wrap handling needed.
- No internal FSM; all sequencing belongs to the controller.
  - Sequential state is the RF and dmem only; every state change is deterministic per edge.

Decomposition:
- cpu_pkg holds:
  - DATA_W, RF_AW, DMEM_AW constants
  - typedef enum logic [1:0] alu_op_e {ALU_PASSP, ALU_ADD, ALU_SUB, ALU_PASSQ}
  - typedef enum logic [1:0] wb_sel_e {WB_ALU, WB_MEM, WB_IMM, WB_ZERO}
- One sub-module, regfile_2r1w: 16x8 array, async active-low clear, two gated read ports, one write port, one debug read port.
- ALU, mux, and dmem stay inline in datapath.

Test Plan:
- Reset then load immediates: rst=0→1; write W_addr=3, s=10, W_data=8'h2A; next cycle Rp_addr=3, Rp_rd=1 → dbg_rf_data[3]=8'h2A and RF_Rp_zero=0.
- Add: r1=8'hF0, r2=8'h20; Rp=1, Rq=2, alu=01, s=00, W_addr=4, W_wr=1 → r4=8'h10 (wrap, carry dropped).
- Store/load: r5=8'h77; Rp=5, D_addr=8'h80, D_wr=1 → dbg_mem_data[80]=8'h77; then D_rd=1, s=01, W_addr=6 → r6=8'h77 in one cycle.
- Read-during-write: r7=8'h01; same cycle Rp=7, W_addr=7, s=10, W_data=8'h00 → RF_Rp_zero=0 that cycle, 1 the next cycle.
- Zero flag gating: r0=0; Rp_addr=0, Rp_rd=0 → RF_Rp_zero=0; Rp_rd=1 → 1; sub r8-r8 (8'h55) written to r9 → r9=0.
- Async reset mid-write: r2=8'h33; assert rst low between edges while W_wr=1 → all registers read 0 immediately, and the write is not committed after rst releases.
